// File: rtl/ifm_window_buffer.sv
// rtl/ifm_window_buffer.sv - packs aligned IFM read words into double-buffered convolution windows
module ifm_window_buffer #(
    parameter int KERNEL_SIZE = 3,
    parameter int IFM_CHANNEL = 3,
    parameter int DATA_WIDTH  = 16,
    parameter int RD_LATENCY  = 1,
    localparam int WIN_WORDS  = KERNEL_SIZE * KERNEL_SIZE * IFM_CHANNEL
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            addr_valid,
    input  logic [DATA_WIDTH-1:0]           ifm_rdata,
    input  logic                            window_ready,
    output logic                            window_valid,
    output logic [WIN_WORDS*DATA_WIDTH-1:0] window_data,
    output logic                            overflow
);

    localparam int CNT_W = (WIN_WORDS > 1) ? $clog2(WIN_WORDS) : 1;
    localparam logic [CNT_W-1:0] LAST_SLOT = CNT_W'(WIN_WORDS - 1);

    logic [RD_LATENCY-1:0]                     rd_pipe_q;
    logic [1:0][WIN_WORDS-1:0][DATA_WIDTH-1:0] bank_q;
    logic [1:0]                                full_q, full_d;
    logic                                      wr_bank_q, wr_bank_d;
    logic                                      rd_bank_q, rd_bank_d;
    logic [CNT_W-1:0]                          wr_cnt_q, wr_cnt_d;
    logic                                      overflow_q, overflow_d;

    logic rd_valid;
    logic accept;
    logic last_word;
    logic handshake;

    assign rd_valid     = rd_pipe_q[RD_LATENCY-1];
    assign window_valid = full_q[rd_bank_q];
    assign window_data  = bank_q[rd_bank_q];
    assign overflow     = overflow_q;

    always_comb begin
        accept     = rd_valid & ~full_q[wr_bank_q];
        last_word  = accept & (wr_cnt_q == LAST_SLOT);
        handshake  = full_q[rd_bank_q] & window_ready;
        full_d     = full_q;
        wr_bank_d  = wr_bank_q;
        rd_bank_d  = rd_bank_q;
        wr_cnt_d   = wr_cnt_q;
        overflow_d = overflow_q | (rd_valid & full_q[wr_bank_q]);
        // Release and completion always hit different banks, so both may apply.
        if (handshake) begin
            full_d[rd_bank_q] = 1'b0;
            rd_bank_d         = ~rd_bank_q;
        end
        if (last_word) begin
            full_d[wr_bank_q] = 1'b1;
            wr_bank_d         = ~wr_bank_q;
            wr_cnt_d          = '0;
        end else if (accept) begin
            wr_cnt_d = wr_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_pipe_q  <= '0;
            bank_q     <= '0;
            full_q     <= '0;
            wr_bank_q  <= 1'b0;
            rd_bank_q  <= 1'b0;
            wr_cnt_q   <= '0;
            overflow_q <= 1'b0;
        end else begin
            rd_pipe_q[0] <= addr_valid;
            for (int i = 1; i < RD_LATENCY; i++) begin
                rd_pipe_q[i] <= rd_pipe_q[i-1];
            end
            if (accept) begin
                bank_q[wr_bank_q][wr_cnt_q] <= ifm_rdata;
            end
            full_q     <= full_d;
            wr_bank_q  <= wr_bank_d;
            rd_bank_q  <= rd_bank_d;
            wr_cnt_q   <= wr_cnt_d;
            overflow_q <= overflow_d;
        end
    end

endmodule

// File: tb/tb_ifm_window_buffer.sv
// tb/tb_ifm_window_buffer.sv - randomized scoreboard bench for ifm_window_buffer
module tb_ifm_window_buffer;

    localparam int K   = 3;
    localparam int C   = 3;
    localparam int DW  = 16;
    localparam int L   = 1;
    localparam int WIN = K * K * C;

    logic                clk = 1'b0;
    logic                rst_n;
    logic                addr_valid;
    logic [DW-1:0]       ifm_rdata;
    logic                window_ready;
    logic                window_valid;
    logic [WIN*DW-1:0]   window_data;
    logic                overflow;

    always #5 clk = ~clk;

    ifm_window_buffer #(
        .KERNEL_SIZE (K),
        .IFM_CHANNEL (C),
        .DATA_WIDTH  (DW),
        .RD_LATENCY  (L)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .addr_valid   (addr_valid),
        .ifm_rdata    (ifm_rdata),
        .window_ready (window_ready),
        .window_valid (window_valid),
        .window_data  (window_data),
        .overflow     (overflow)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: words in arrival order, completed windows in order, held-window count.
    logic [WIN*DW-1:0] exp_q[$];
    logic [DW-1:0]     cur_q[$];
    int                held_cnt;
    bit                m_ovf;
    bit                hist_v[L];
    logic [DW-1:0]     hist_d[L];

    task automatic check(input string name, input logic [WIN*DW-1:0] act, input logic [WIN*DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        cur_q.delete();
        exp_q.delete();
        held_cnt = 0;
        m_ovf    = 1'b0;
        for (int i = 0; i < L; i++) begin
            hist_v[i] = 1'b0;
            hist_d[i] = '0;
        end
    endtask

    task automatic cycle(input bit av, input logic [DW-1:0] val, input bit rdy);
        int                pre;
        logic [WIN*DW-1:0] w;
        @(negedge clk);
        check("window_valid", {431'd0, window_valid}, {431'd0, held_cnt > 0});
        check("overflow", {431'd0, overflow}, {431'd0, m_ovf});
        addr_valid   = av;
        window_ready = rdy;
        ifm_rdata    = hist_v[L-1] ? hist_d[L-1] : DW'($urandom);
        pre = held_cnt;
        if (pre > 0 && rdy) held_cnt--;
        if (hist_v[L-1]) begin
            if (pre == 2) begin
                m_ovf = 1'b1;
            end else begin
                cur_q.push_back(hist_d[L-1]);
                if (cur_q.size() == WIN) begin
                    w = '0;
                    for (int i = 0; i < WIN; i++) w[i*DW +: DW] = cur_q[i];
                    exp_q.push_back(w);
                    cur_q.delete();
                    held_cnt++;
                end
            end
        end
        for (int i = L - 1; i > 0; i--) begin
            hist_v[i] = hist_v[i-1];
            hist_d[i] = hist_d[i-1];
        end
        hist_v[0] = av;
        hist_d[0] = val;
    endtask

    task automatic idle(input int n, input bit rdy);
        for (int i = 0; i < n; i++) cycle(1'b0, '0, rdy);
    endtask

    task automatic send_window(input int base, input bit rdy);
        for (int i = 0; i < WIN; i++) cycle(1'b1, DW'(base + i), rdy);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n        = 1'b0;
        addr_valid   = 1'b0;
        window_ready = 1'b0;
        model_reset();
        #1;
        check("reset_valid", {431'd0, window_valid}, '0);
        check("reset_overflow", {431'd0, overflow}, '0);
        check("reset_data", window_data, '0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (rst_n === 1'b1 && window_valid === 1'b1 && window_ready === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL window_unexpected: got %h expected no window", window_data);
                end else begin
                    check("window_data", window_data, exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        #3000000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n        = 1'b0;
        addr_valid   = 1'b0;
        window_ready = 1'b0;
        ifm_rdata    = '0;
        model_reset();
        do_reset();

        // Single window with ready held high.
        send_window(1, 1'b1);
        idle(L + 4, 1'b1);

        // Back-pressure: two windows held, released by single ready pulses.
        send_window(1, 1'b0);
        send_window(101, 1'b0);
        idle(L + 4, 1'b0);
        idle(1, 1'b1);
        idle(3, 1'b0);
        idle(1, 1'b1);
        idle(3, 1'b0);

        // Overflow: third window dropped while both banks are full.
        send_window(1, 1'b0);
        send_window(101, 1'b0);
        send_window(301, 1'b0);
        idle(L + 2, 1'b0);
        idle(1, 1'b1);
        idle(2, 1'b0);
        idle(1, 1'b1);
        idle(3, 1'b0);
        do_reset();

        // Gapped input: bursts of three words, five idle cycles between.
        for (int b = 0; b < WIN / 3; b++) begin
            for (int j = 0; j < 3; j++) cycle(1'b1, DW'(1 + b * 3 + j), 1'b1);
            idle(5, 1'b1);
        end
        idle(L + 3, 1'b1);

        // Reset mid-fill, then a clean window.
        for (int i = 0; i < 10; i++) cycle(1'b1, DW'(500 + i), 1'b0);
        do_reset();
        send_window(201, 1'b1);
        idle(L + 3, 1'b1);

        // Release of one bank on the same edge the other bank completes.
        send_window(1, 1'b0);
        send_window(101, 1'b0);
        idle(L - 1, 1'b0);
        idle(1, 1'b1);
        idle(1, 1'b0);
        idle(3, 1'b1);

        // Randomized traffic with varying back-pressure.
        for (int seg = 0; seg < 6; seg++) begin
            int rp;
            rp = $urandom_range(0, 9);
            if (seg == 3) do_reset();
            for (int i = 0; i < 400; i++) begin
                cycle($urandom_range(0, 3) != 0, DW'($urandom), $urandom_range(0, 9) < rp);
            end
        end

        idle(L + 6, 1'b1);
        check("drain_empty", WIN*DW'(exp_q.size()), '0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
